// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
//
// Parametrised serial-in / parallel-out deserializer. Serial bits qualified by
// in_valid are shifted into a live register (q); a bit counter frames them
// into WIDTH-bit words. Each completed word is copied into a holding register
// (dout) offered downstream through a valid/ready handshake. A word that
// completes while the previous one is still pending is dropped and flagged by
// the sticky overrun output.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: first received bit ends up in dout[WIDTH-1]
//              0: first received bit ends up in dout[0]
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in          serial data bit
//   in_valid    qualifies in
//   clear       synchronous framing restart (q, bit_cnt, overrun); dout kept
//   q           live shift register contents
//   bit_cnt     bits accepted into the current frame
//   dout        completed word, stable while dout_valid=1
//   dout_valid  dout holds an unconsumed word
//   dout_ready  downstream accepts dout when dout_valid & dout_ready
//   overrun     sticky: a completed word was dropped
//   parity_err  (SIPO_DESER_PARITY_EN only) XOR of data and parity bit,
//               loaded and held with dout
//
// Build option:
//   SIPO_DESER_PARITY_EN  frames become WIDTH+1 bits; the last bit is an
//                         even-parity bit that is checked but not shifted
//                         into q.
// -----------------------------------------------------------------------------
module sipo_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1,
`else
    localparam int unsigned FRAME_LEN = WIDTH,
`endif
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_q,          q_d;
    logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q,    overrun_d;
`ifdef SIPO_DESER_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic             consume;
    logic             is_data;
    logic             is_last;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;

    // Shift network, bit order fixed at elaboration
    always_comb begin
        shifted = q_q;
        if (MSB_FIRST) begin
            shifted = {q_q[WIDTH-2:0], in};
        end else begin
            shifted = {in, q_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        // clear suppresses consumption of the serial bit on its edge
        consume = in_valid & ~clear;
        is_data = consume && (bit_cnt_q < CNT_WIDTH);
        is_last = consume && (bit_cnt_q == CNT_LAST);
`ifdef SIPO_DESER_PARITY_EN
        // The parity bit arrives after all data is already in q
        word = q_q;
`else
        // Completing word includes the bit consumed on this edge
        word = shifted;
`endif
    end

    always_comb begin
        q_d          = q_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // Framing side
        if (clear) begin
            q_d       = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (consume) begin
            if (is_data) begin
                q_d = shifted;
            end
            if (is_last) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Handshake side; runs even on a clear edge
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // A completing word may load if the holding register is free or
        // being emptied on this very edge; otherwise it is dropped.
        if (is_last) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
                parity_err_d = (^q_q) ^ in;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q          <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            q_q          <= q_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_DESER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign q          = q_q;
    assign bit_cnt    = bit_cnt_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
